// File: rtl/timer_irq_unit.sv
// Memory-mapped interval timer with auto-reload, prescaler, interrupt flag and a
// free-running system tick counter, sitting on the CPU peripheral bus.
module timer_irq_unit #(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);

  localparam logic [29:0] W_TH   = BASE_ADDR[31:2];
  localparam logic [29:0] W_TL   = W_TH + 30'd1;
  localparam logic [29:0] W_TCON = W_TH + 30'd2;
  localparam logic [29:0] W_SYS  = W_TH + 30'd5;
  localparam logic [15:0] PC_LAST = 16'(PRESCALE - 1);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [31:0] sys_q, sys_d;
  logic [15:0] pc_q, pc_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        if_q, if_d;

  logic sel_th, sel_tl, sel_tcon, sel_sys;
  logic tick, ovf;
  logic unused_byte_sel;

  assign unused_byte_sel = ^addr[1:0];

  assign sel_th   = (addr[31:2] == W_TH);
  assign sel_tl   = (addr[31:2] == W_TL);
  assign sel_tcon = (addr[31:2] == W_TCON);
  assign sel_sys  = (addr[31:2] == W_SYS);

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_th)        rdata = th_q;
      else if (sel_tl)   rdata = tl_q;
      else if (sel_tcon) rdata = {29'd0, if_q, ie_q, en_q};
      else if (sel_sys)  rdata = sys_q;
    end
  end

  assign irqout = ie_q & if_q;

  // Software writes are applied after the hardware update so they take priority,
  // except that an overflow always gets to set IF so no interrupt is dropped.
  always_comb begin
    tick  = en_q && (pc_q == PC_LAST);
    ovf   = tick && (tl_q == 32'hFFFF_FFFF);
    th_d  = th_q;
    tl_d  = tl_q;
    en_d  = en_q;
    ie_d  = ie_q;
    sys_d = sys_q + 32'd1;
    if_d  = if_q | (ovf & ie_q);

    if (!en_q || tick) pc_d = '0;
    else               pc_d = pc_q + 16'd1;

    if (tick) tl_d = ovf ? th_q : tl_q + 32'd1;

    if (wr && sel_th) th_d = wdata;
    if (wr && sel_tl) begin
      tl_d = wdata;
      pc_d = '0;
    end
    if (wr && sel_tcon) begin
      en_d = wdata[0];
      ie_d = wdata[1];
      if_d = wdata[2] | (ovf & (ie_q | wdata[1]));
      if (!wdata[0]) pc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q  <= '0;
      tl_q  <= '0;
      sys_q <= '0;
      pc_q  <= '0;
      en_q  <= 1'b0;
      ie_q  <= 1'b0;
      if_q  <= 1'b0;
    end else begin
      th_q  <= th_d;
      tl_q  <= tl_d;
      sys_q <= sys_d;
      pc_q  <= pc_d;
      en_q  <= en_d;
      ie_q  <= ie_d;
      if_q  <= if_d;
    end
  end

endmodule

// File: tb/tb_timer_irq_unit.sv
// Bench for timer_irq_unit: two instances (PRESCALE 1 and 4) share one bus and are
// compared against a behavioural model plus directed expectations.
module tb_timer_irq_unit;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE;
  localparam logic [31:0] A_TL   = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_UNM  = BASE + 32'h0C;
  localparam logic [31:0] A_SYS  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_irq_unit #(.PRESCALE(1), .BASE_ADDR(BASE)) dut_a (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .irqout(irq_a));

  timer_irq_unit #(.PRESCALE(4), .BASE_ADDR(BASE)) dut_b (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .irqout(irq_b));

  // Reference model: prescaling is tracked as a count of enabled cycles since the
  // last restart, ticking whenever that count reaches a multiple of the prescale.
  logic [31:0] m_th[2], m_tl[2], m_sys[2];
  logic        m_en[2], m_ie[2], m_if[2];
  int unsigned m_run[2];
  int unsigned ps[2] = '{1, 4};

  function automatic logic [31:0] exp_rdata(int i);
    logic [31:0] off;
    if (!rd) return 32'd0;
    off = {addr[31:2], 2'b00} - BASE;
    case (off)
      32'h00:  return m_th[i];
      32'h04:  return m_tl[i];
      32'h08:  return {29'd0, m_if[i], m_ie[i], m_en[i]};
      32'h14:  return m_sys[i];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_irq(int i);
    return m_ie[i] & m_if[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_th[i] = '0; m_tl[i] = '0; m_sys[i] = '0;
      m_en[i] = 1'b0; m_ie[i] = 1'b0; m_if[i] = 1'b0; m_run[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [31:0] off;
    off = {addr[31:2], 2'b00} - BASE;
    for (int i = 0; i < 2; i++) begin
      logic tick, ovf, n_en, n_ie, n_if;
      logic [31:0] n_th, n_tl;
      int unsigned n_run;
      tick  = m_en[i] && (((m_run[i] + 1) % ps[i]) == 0);
      ovf   = tick && (m_tl[i] == 32'hFFFF_FFFF);
      n_th  = m_th[i];
      n_en  = m_en[i];
      n_ie  = m_ie[i];
      n_tl  = !tick ? m_tl[i] : (ovf ? m_th[i] : m_tl[i] + 32'd1);
      n_run = m_en[i] ? m_run[i] + 1 : 0;
      n_if  = m_if[i] | (ovf & m_ie[i]);
      if (wr) begin
        case (off)
          32'h00: n_th = wdata;
          32'h04: begin n_tl = wdata; n_run = 0; end
          32'h08: begin
            n_en = wdata[0];
            n_ie = wdata[1];
            n_if = wdata[2] | (ovf & (m_ie[i] | wdata[1]));
            if (!wdata[0]) n_run = 0;
          end
          default: ;
        endcase
      end
      m_th[i] = n_th; m_tl[i] = n_tl; m_en[i] = n_en; m_ie[i] = n_ie;
      m_if[i] = n_if; m_run[i] = n_run; m_sys[i] = m_sys[i] + 32'd1;
    end
  endtask

  task automatic set_bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    set_bus(1'b0, 1'b1, a, d);
    step();
  endtask

  task automatic test_reset();
    write_reg(A_TH, 32'hFFFF_FFF0);
    write_reg(A_TL, 32'hFFFF_FFFD);
    write_reg(A_TCON, 32'd3);
    set_bus(1'b0, 1'b0, '0, '0);
    repeat (5) step();
    checks++; if (irq_a !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_irq got %b want 1", irq_a); end
    set_bus(1'b1, 1'b0, A_TCON, '0);
    #2 reset = 1'b1;
    #1;
    checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b/%b want 0/0", irq_a, irq_b); end
    checks++; if (rdata_a !== 32'd0) begin errors++; $display("[TB] FAIL reset_tcon got %h want 0", rdata_a); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (10) step();
    set_bus(1'b1, 1'b0, A_SYS, '0);
    checks++; if (rdata_a !== 32'd10 || rdata_b !== 32'd10) begin errors++; $display("[TB] FAIL systick got %0d/%0d want 10", rdata_a, rdata_b); end
    step();
    set_bus(1'b1, 1'b0, A_TL, '0);
    checks++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin errors++; $display("[TB] FAIL reset_tl got %h/%h want 0", rdata_a, rdata_b); end
    step();
    set_bus(1'b1, 1'b0, A_TCON, '0);
    checks++; if (rdata_a !== 32'd0 || irq_a !== 1'b0) begin errors++; $display("[TB] FAIL idle_tcon got %h irq %b want 0 irq 0", rdata_a, irq_a); end
    step();
  endtask

  task automatic test_basic_overflow();
    logic [31:0] want_tl[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    logic        want_irq[3] = '{1'b0, 1'b0, 1'b1};
    write_reg(A_TH, 32'hFFFF_FFFC);
    write_reg(A_TL, 32'hFFFF_FFFE);
    write_reg(A_TCON, 32'd3);
    for (int k = 0; k < 3; k++) begin
      set_bus(1'b1, 1'b0, A_TL, '0);
      checks++; if (rdata_a !== want_tl[k] || irq_a !== want_irq[k]) begin errors++; $display("[TB] FAIL ovf_seq%0d got %h irq %b want %h irq %b", k, rdata_a, irq_a, want_tl[k], want_irq[k]); end
      checks++; if (rdata_b !== exp_rdata(1)) begin errors++; $display("[TB] FAIL ovf_b%0d got %h want %h", k, rdata_b, exp_rdata(1)); end
      step();
    end
    set_bus(1'b1, 1'b0, A_TCON, '0);
    checks++; if (rdata_a !== 32'd7) begin errors++; $display("[TB] FAIL ovf_if got %h want 7", rdata_a); end
    step();
    set_bus(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (irq_a !== 1'b1) begin errors++; $display("[TB] FAIL irq_held%0d got %b want 1", k, irq_a); end
    end
  endtask

  task automatic test_isr_clear();
    int n;
    write_reg(A_TL, 32'd0);
    write_reg(A_TCON, 32'd3);
    set_bus(1'b1, 1'b0, A_TCON, '0);
    checks++; if (rdata_a !== 32'd3 || irq_a !== 1'b0) begin errors++; $display("[TB] FAIL isr_clear got %h irq %b want 3 irq 0", rdata_a, irq_a); end
    step();
    write_reg(A_TL, 32'hFFFF_FFFC);
    set_bus(1'b0, 1'b0, '0, '0);
    n = 0;
    while (irq_a !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++; if (n != 4) begin errors++; $display("[TB] FAIL isr_reoverflow got %0d ticks want 4", n); end
  endtask

  task automatic test_simul_clear();
    write_reg(A_TL, 32'hFFFF_FFFE);
    set_bus(1'b0, 1'b0, '0, '0);
    step();
    write_reg(A_TCON, 32'd3);
    set_bus(1'b1, 1'b0, A_TCON, '0);
    checks++; if (rdata_a !== 32'd7 || irq_a !== 1'b1) begin errors++; $display("[TB] FAIL simul_clear got %h irq %b want 7 irq 1", rdata_a, irq_a); end
    step();
    set_bus(1'b1, 1'b0, A_TL, '0);
    checks++; if (rdata_a !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL simul_reload got %h want fffffffd", rdata_a); end
    step();
  endtask

  task automatic test_prescale();
    int n;
    write_reg(A_TCON, 32'd0);
    write_reg(A_TL, 32'd0);
    write_reg(A_TCON, 32'd1);
    set_bus(1'b0, 1'b0, '0, '0);
    repeat (16) step();
    set_bus(1'b1, 1'b0, A_TL, '0);
    checks++; if (rdata_b !== 32'd4) begin errors++; $display("[TB] FAIL prescale_tl got %0d want 4", rdata_b); end
    checks++; if (rdata_a !== 32'd16) begin errors++; $display("[TB] FAIL noprescale_tl got %0d want 16", rdata_a); end
    step();
    set_bus(1'b0, 1'b0, '0, '0);
    step();
    write_reg(A_TCON, 32'd0);
    set_bus(1'b0, 1'b0, '0, '0);
    repeat (2) step();
    write_reg(A_TCON, 32'd1);
    n = 0;
    set_bus(1'b1, 1'b0, A_TL, '0);
    while (rdata_b !== 32'd5 && n < 20) begin
      step();
      n++;
      set_bus(1'b1, 1'b0, A_TL, '0);
    end
    checks++; if (n != 4) begin errors++; $display("[TB] FAIL reenable_tick got %0d cycles want 4", n); end
    step();
  endtask

  task automatic test_tl_priority();
    write_reg(A_TCON, 32'd0);
    write_reg(A_TL, 32'hFFFF_FFFE);
    write_reg(A_TCON, 32'd3);
    set_bus(1'b0, 1'b0, '0, '0);
    step();
    write_reg(A_TL, 32'd5);
    set_bus(1'b1, 1'b0, A_TL, '0);
    checks++; if (rdata_a !== 32'd5) begin errors++; $display("[TB] FAIL tl_wins got %h want 5", rdata_a); end
    step();
    set_bus(1'b1, 1'b0, A_TCON, '0);
    checks++; if (rdata_a !== 32'd7 || irq_a !== 1'b1) begin errors++; $display("[TB] FAIL tl_wins_if got %h irq %b want 7 irq 1", rdata_a, irq_a); end
    step();
  endtask

  task automatic test_unmapped();
    write_reg(A_TCON, 32'd0);
    write_reg(A_TH, 32'h1234);
    write_reg(A_TL, 32'h55);
    write_reg(A_UNM, 32'hFFFF_FFFF);
    write_reg(32'h0000_0008, 32'hFFFF_FFFF);
    set_bus(1'b1, 1'b0, A_UNM, '0);
    checks++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin errors++; $display("[TB] FAIL unm_read got %h/%h want 0", rdata_a, rdata_b); end
    step();
    set_bus(1'b1, 1'b0, A_TH, '0);
    checks++; if (rdata_a !== 32'h1234) begin errors++; $display("[TB] FAIL unm_th got %h want 1234", rdata_a); end
    step();
    set_bus(1'b1, 1'b0, A_TL, '0);
    checks++; if (rdata_a !== 32'h55) begin errors++; $display("[TB] FAIL unm_tl got %h want 55", rdata_a); end
    step();
    set_bus(1'b1, 1'b0, A_TCON, '0);
    checks++; if (rdata_a !== 32'd0) begin errors++; $display("[TB] FAIL unm_tcon got %h want 0", rdata_a); end
    step();
    set_bus(1'b0, 1'b0, A_TL, '0);
    checks++; if (rdata_a !== 32'd0) begin errors++; $display("[TB] FAIL rd_low got %h want 0", rdata_a); end
    step();
    set_bus(1'b1, 1'b1, A_TH, 32'hABCD);
    checks++; if (rdata_a !== 32'h1234) begin errors++; $display("[TB] FAIL rd_wr_old got %h want 1234", rdata_a); end
    step();
    set_bus(1'b1, 1'b0, A_TH + 32'd3, '0);
    checks++; if (rdata_a !== 32'hABCD) begin errors++; $display("[TB] FAIL rd_wr_new got %h want abcd", rdata_a); end
    step();
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic        r, w;
    int          sel;
    for (int k = 0; k < 600; k++) begin
      r   = 1'($urandom_range(0, 1));
      w   = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 7);
      d   = $urandom();
      case (sel)
        0: a = A_TH;
        1: a = A_TL;
        2, 7: a = A_TCON;
        3: a = A_UNM;
        4: a = A_SYS;
        5: a = BASE + 32'h10;
        default: a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      endcase
      if ((sel <= 1) && ($urandom_range(0, 3) != 0)) d = 32'hFFFF_FFF0 | {28'd0, d[3:0]};
      if ((sel == 2 || sel == 7) && ($urandom_range(0, 4) != 0)) d[0] = 1'b1;
      a = a + 32'($urandom_range(0, 3));
      set_bus(r, w, a, d);
      checks++; if (rdata_a !== exp_rdata(0) || rdata_b !== exp_rdata(1)) begin errors++; $display("[TB] FAIL rand_rdata%0d got %h/%h want %h/%h", k, rdata_a, rdata_b, exp_rdata(0), exp_rdata(1)); end
      checks++; if (irq_a !== exp_irq(0) || irq_b !== exp_irq(1)) begin errors++; $display("[TB] FAIL rand_irq%0d got %b/%b want %b/%b", k, irq_a, irq_b, exp_irq(0), exp_irq(1)); end
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic_overflow();
    test_isr_clear();
    test_simul_clear();
    test_prescale();
    test_tl_priority();
    test_unmapped();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_irq_unit.md
Name: timer_irq_unit

Overview:
- Memory-mapped interval timer and system tick counter on the CPU peripheral bus (address bit 30 set).
- Produces the `irqout` level that feeds the CPU control unit's IRQ input. The CPU uses it to vector to 0x80000004.
- Sits beside the data memory on the shared `rd`/`wr`/`addr`/`wdata` bus. Its read data is muxed onto the load path by the CPU.

Parameters:
- PRESCALE, 1, number of enabled clk cycles per TL increment (1..65535; 1 = every cycle)
- BASE_ADDR, 32'h40000000, base of the register window; registers at word offsets +0x00, +0x04, +0x08, +0x14

Ports:
- clk  input  1  CPU core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- rd  input  1  read strobe (MemRead & addr[30])
- wr  input  1  write strobe (MemWrite & addr[30]), sampled at rising clk
- addr  input  32  byte address; only addr[31:2] decoded, addr[1:0] ignored
- wdata  input  32  write data
- rdata  output  32  read data, combinational
- irqout  output  1  interrupt request level to CPU

Behaviour:
- Registers:
  - TH (+0x00), R/W reload value.
  - TL (+0x04), R/W counter.
  - TCON (+0x08), R/W:
    - bit0 = EN (count enable)
    - bit1 = IE (interrupt enable)
    - bit2 = IF (interrupt flag)
    - bits 31:3 read 0 and are ignored on write.
  - SYSTICK (+0x14), read-only; writes ignored.
- Reset values: TH=0, TL=0, TCON=0, SYSTICK=0, prescale counter=0, rdata=0, irqout=0.
- rdata:
  - When rd=1 and addr matches a register, rdata = that register's current (pre-edge) value, combinationally.
  - Otherwise rdata=0, including rd=0, unmapped offsets and addresses outside the window.
- SYSTICK increments by 1 every clk regardless of EN. It wraps 32'hFFFFFFFF -> 0.
- Prescaler:
  - Internal 16-bit counter pc. While EN=1: pc increments each cycle.
  - When pc == PRESCALE-1, a tick is generated and pc returns to 0.
  - While EN=0, pc holds at 0.
  - PRESCALE=1 gives a tick every enabled cycle.
- Tick action:
  - If TL == 32'hFFFFFFFF: TL <= TH (overflow), and IF <= 1 if IE=1.
  - Otherwise TL <= TL+1.
- irqout = IE & IF, registered view of TCON. It rises the cycle after the overflow edge and stays high until IF or IE is cleared.
- Software writes:
  - TH write: takes effect at the edge. If an overflow happens on the same edge, TL reloads from the OLD TH.
  - TL write: wins over a same-cycle tick or overflow. pc is cleared to 0. The overflow's IF set still occurs if the old TL overflowed.
  - TCON write: EN, IE and IF are loaded from wdata[2:0].
    - If a same-cycle overflow with IE (new or old =1) occurs, IF is forced to 1. A hardware set wins over a software clear, so no interrupt is lost.
    - Writing EN=0 clears pc.
- IF is never cleared by hardware. The ISR clears it by writing TCON with bit2=0, typically writing 3'b011 to re-arm.
- reset asserted mid-count clears everything asynchronously. Counting resumes only after software sets EN.
- No write side effects for addresses outside the window. rd and wr together in one cycle: the read returns the pre-write value.

Test Plan:
- Reset and idle:
  - Stimulus: assert reset mid-run, release, hold 10 cycles.
  - Required: TL=0, TCON=0, irqout=0, SYSTICK read = cycles since release.
- Basic overflow (PRESCALE=1):
  - Stimulus: write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3.
  - Required: TL reads FFFFFFFF, then FFFFFFFC; IF=1 on the overflow edge; irqout=1 the next cycle and held.
- ISR clear:
  - Stimulus: with irqout=1, write TCON=3.
  - Required: irqout=0 after the edge; next overflow after TH-to-FFFFFFFF distance+1 ticks, i.e. 4 ticks for TH=FFFFFFFC.
- Simultaneous clear and overflow:
  - Stimulus: write TCON=3 on the exact cycle TL overflows.
  - Required: IF reads 1, irqout stays 1.
- Prescale (PRESCALE=4):
  - Stimulus: TL=0, TCON=1 for 16 cycles.
  - Required: TL=4.
  - Stimulus: write EN=0 at cycle 2 of a prescale period, re-enable.
  - Required: first tick 4 cycles after re-enable.
- TL write priority:
  - Stimulus: write TL=5 on an overflow edge with IE=1.
  - Required: TL=5 and IF=1.
  - Stimulus: write an unmapped offset +0x0C.
  - Required: no state change; read of +0x0C returns 0.
